mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
// - Memory-access stage directly downstream of the ALU: consumes ALU result y (result or effective address) plus store data and destination reg.
// - Performs load/store over a req/ack data-memory handshake; pass-through ops retire in 1 cycle.
// - Emits one registered writeback beat per accepted op to the register-file write port; stalls execute via in_ready.
// PARAMETERS
// - D_WIDTH   32  data / ALU result width
// - RF_AW     5   register-file address width
// PORTS
// - clk          in   1        single clock, rising edge
// - rst_n        in   1        asynchronous, active-low reset
// - in_valid     in   1        execute stage presents an op
// - in_ready     out  1        stage accepts op this cycle
// - in_memop     in   2        00 PASS, 01 LOAD, 10 STORE, 11 reserved (treated as PASS)
// - in_y         in   D_WIDTH  ALU result / word address
// - in_sdata     in   D_WIDTH  store data
// - in_rd        in   RF_AW    destination register
// - in_regwr     in   1        op writes rd
// - dmem_req     out  1        memory request, held until ack
// - dmem_we      out  1        1 = store
// - dmem_addr    out  D_WIDTH  byte address (word aligned)
// - dmem_wdata   out  D_WIDTH  store data
// - dmem_rdata   in   D_WIDTH  load data, valid with ack
// - dmem_ack     in   1        completes request
// - wb_valid     out  1        one-cycle retire pulse
// - wb_we        out  1        register-file write enable
// - wb_rd        out  RF_AW    write address
// - wb_data      out  D_WIDTH  write data
// - misalign     out  1        one-cycle pulse with wb_valid on misaligned access
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; in_ready=0 during reset; all outputs 0; any in-flight request abandoned (dmem_req drops immediately).
// - FSM: IDLE, ACCESS. in_ready = (state==IDLE). Accept = in_valid & in_ready at a rising edge.
// - IDLE, accept PASS: next cycle wb_valid=1, wb_data=in_y, wb_rd=in_rd, wb_we=in_regwr & (in_rd!=0); stay IDLE (1 op/cycle throughput).
// - IDLE, accept LOAD/STORE with in_y[1:0]==0: capture addr/sdata/rd/regwr/op, go ACCESS; no wb that cycle.
// - IDLE, accept LOAD/STORE with in_y[1:0]!=0: no request; next cycle wb_valid=1, wb_we=0, misalign=1; stay IDLE.
// - ACCESS: dmem_req=1, dmem_we=(op==STORE), addr/wdata stable from captured values until ack.
// - ACCESS, ack sampled high: next cycle dmem_req=0, state=IDLE, wb_valid=1; LOAD: wb_data=dmem_rdata (sampled at ack edge), wb_we=regwr&(rd!=0); STORE: wb_we=0, wb_data=0.
// - Ack permitted in first ACCESS cycle (min load latency: accept edge -> wb_valid 2 cycles later). No timeout; ack held low stalls indefinitely.
// - dmem_ack while not in ACCESS: ignored. dmem_rdata ignored unless LOAD ack.
// - in_valid with in_ready=0: op not consumed; upstream holds it (valid must stay stable).
// - wb_valid, misalign are single-cycle pulses; wb_* fields hold last value otherwise, wb_we forced 0 when wb_valid=0.
// - rd==0 never written (wb_we=0) even if in_regwr=1.
// STRUCTURE
// - Shared package: memop encodings (MEMOP_PASS/LOAD/STORE), state encodings, D_WIDTH/RF_AW defaults.
// - Single module; no sub-module (FSM plus capture registers is small enough to stay flat).
// TESTING
// - PASS in_y=0x1234, rd=5, regwr=1 on back-to-back cycles -> wb_valid each next cycle, wb_data=0x1234, wb_we=1, in_ready stays 1.
// - LOAD addr=0x100 rd=3, ack after 3 cycles with rdata=0xDEADBEEF -> req held 3 cycles, wb_data=0xDEADBEEF, wb_rd=3, wb_we=1.
// - STORE addr=0x200 sdata=0xCAFE, ack in first cycle -> req 1 cycle, we=1, wdata=0xCAFE, wb_valid with wb_we=0.
// - LOAD addr=0x102 -> no dmem_req, wb_valid=1, misalign=1, wb_we=0.
// - PASS rd=0 regwr=1 -> wb_valid=1, wb_we=0; stray ack in IDLE -> no effect.
// - rst_n low mid-ACCESS -> dmem_req drops immediately, state IDLE, no wb_valid after release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings and default widths for the memory-access stage.
package mem_stage_pkg;

   localparam int unsigned D_WIDTH_DEF = 32;
   localparam int unsigned RF_AW_DEF   = 5;
   localparam int unsigned MEMOP_W     = 2;

   localparam logic [MEMOP_W-1:0] MEMOP_PASS  = 2'b00;
   localparam logic [MEMOP_W-1:0] MEMOP_LOAD  = 2'b01;
   localparam logic [MEMOP_W-1:0] MEMOP_STORE = 2'b10;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   // Reserved encoding 2'b11 behaves as PASS.
   function automatic logic is_memop(input logic [MEMOP_W-1:0] op);
      return (op == MEMOP_LOAD) || (op == MEMOP_STORE);
   endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: retires PASS ops in one cycle, runs LOAD/STORE over a
// req/ack data-memory handshake, and emits one registered writeback beat per op.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned D_WIDTH = D_WIDTH_DEF,
   parameter int unsigned RF_AW   = RF_AW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_memop,
   input  logic [D_WIDTH-1:0] in_y,
   input  logic [D_WIDTH-1:0] in_sdata,
   input  logic [RF_AW-1:0]   in_rd,
   input  logic               in_regwr,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [D_WIDTH-1:0] dmem_addr,
   output logic [D_WIDTH-1:0] dmem_wdata,
   input  logic [D_WIDTH-1:0] dmem_rdata,
   input  logic               dmem_ack,
   output logic               wb_valid,
   output logic               wb_we,
   output logic [RF_AW-1:0]   wb_rd,
   output logic [D_WIDTH-1:0] wb_data,
   output logic               misalign
);

   logic [0:0]         r_state;
   logic [0:0]         w_state_nx;
   logic               r_ready;
   logic               r_req;
   logic               r_we;
   logic [D_WIDTH-1:0] r_addr;
   logic [D_WIDTH-1:0] r_wdata;
   logic [RF_AW-1:0]   r_rd;
   logic               r_regwr;
   logic               r_wb_valid;
   logic               r_wb_we;
   logic [RF_AW-1:0]   r_wb_rd;
   logic [D_WIDTH-1:0] r_wb_data;
   logic               r_misalign;

   logic               w_accept;
   logic               w_capture;
   logic               w_wb_valid_nx;
   logic               w_wb_we_nx;
   logic [RF_AW-1:0]   w_wb_rd_nx;
   logic [D_WIDTH-1:0] w_wb_data_nx;
   logic               w_misalign_nx;

   assign w_accept = in_valid & r_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   // Next state and next writeback beat.
   always_comb begin
      w_state_nx    = r_state;
      w_capture     = 1'b0;
      w_wb_valid_nx = 1'b0;
      w_wb_we_nx    = 1'b0;
      w_misalign_nx = 1'b0;
      w_wb_rd_nx    = r_wb_rd;
      w_wb_data_nx  = r_wb_data;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (!is_memop(in_memop)) begin
                  w_wb_valid_nx = 1'b1;
                  w_wb_we_nx    = in_regwr & (in_rd != '0);
                  w_wb_rd_nx    = in_rd;
                  w_wb_data_nx  = in_y;
               end else if (in_y[1:0] == 2'b00) begin
                  w_capture  = 1'b1;
                  w_state_nx = ST_ACCESS;
               end else begin
                  w_wb_valid_nx = 1'b1;
                  w_misalign_nx = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            if (dmem_ack) begin
               w_state_nx    = ST_IDLE;
               w_wb_valid_nx = 1'b1;
               w_wb_rd_nx    = r_rd;
               if (r_we) begin
                  w_wb_data_nx = '0;
               end else begin
                  w_wb_data_nx = dmem_rdata;
                  w_wb_we_nx   = r_regwr & (r_rd != '0);
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Handshake flags track the next state so reset drops them immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         r_ready <= (w_state_nx == ST_IDLE);
         r_req   <= (w_state_nx == ST_ACCESS);
      end
   end

   // Request payload captured at accept, stable through the access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd    <= '0;
         r_regwr <= 1'b0;
      end else if (w_capture) begin
         r_we    <= (in_memop == MEMOP_STORE);
         r_addr  <= in_y;
         r_wdata <= in_sdata;
         r_rd    <= in_rd;
         r_regwr <= in_regwr;
      end
   end

   // Writeback beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb_we    <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_wb_valid <= w_wb_valid_nx;
         r_wb_we    <= w_wb_we_nx;
         r_wb_rd    <= w_wb_rd_nx;
         r_wb_data  <= w_wb_data_nx;
         r_misalign <= w_misalign_nx;
      end
   end

   assign in_ready   = r_ready;
   assign dmem_req   = r_req;
   assign dmem_we    = r_req & r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;
   assign wb_valid   = r_wb_valid;
   assign wb_we      = r_wb_we;
   assign wb_rd      = r_wb_rd;
   assign wb_data    = r_wb_data;
   assign misalign   = r_misalign;

endmodule
